// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: data/address widths,
// source-select enum and the async result FIFO entry.
package rf_wb_arbiter_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_ASYNC
  } src_e;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Synchronous FIFO of writeback entries; a push while full is dropped,
// and a pop of an empty FIFO is ignored. DEPTH must be a power of 2.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; clearing the pointers is enough to discard entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single RF write-port master merging pipeline writebacks with buffered async
// results, plus a pending-destination scoreboard. Define WB_TRACE_EN to trace writes.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_we,
  input  logic [AW-1:0]               pipe_rd,
  input  logic [DW-1:0]               pipe_wd,
  output logic                        pipe_hold,
  input  logic                        as_valid,
  output logic                        as_ready,
  input  logic [AW-1:0]               as_rd,
  input  logic [DW-1:0]               as_wd,
  input  logic                        iss_valid,
  input  logic [AW-1:0]               iss_rd,
  output logic [31:0]                 pend_mask,
  output logic [AW-1:0]               A3,
  output logic [DW-1:0]               WD,
  output logic                        RFWr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic          p_sel, pop, push, full, empty;
  wb_entry_t     head, push_data;
  src_e          sel;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          rfwr_q, rfwr_d;
  logic          hold_q, hold_d;
  logic [31:0]   pend_q, pend_d, set_vec, clr_vec;
  logic [SW-1:0] starve_q, starve_d;

  assign push_data = '{rd: as_rd, wd: as_wd};
  assign push      = as_valid && !full;
  assign as_ready  = !full;
  assign A3        = a3_q;
  assign WD        = wd_q;
  assign RFWr      = rfwr_q;
  assign pipe_hold = hold_q;
  assign pend_mask = pend_q;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    p_sel  = pipe_we && (pipe_rd != '0);
    pop    = !p_sel && !empty;
    sel    = p_sel ? SRC_PIPE : (pop ? SRC_ASYNC : SRC_NONE);
    a3_d   = a3_q;
    wd_d   = wd_q;
    rfwr_d = 1'b0;
    case (sel)
      SRC_PIPE: begin
        a3_d   = pipe_rd;
        wd_d   = pipe_wd;
        rfwr_d = 1'b1;
      end
      // An r0 entry still consumes its slot but never reaches the RF.
      SRC_ASYNC: begin
        if (head.rd != '0) begin
          a3_d   = head.rd;
          wd_d   = head.wd;
          rfwr_d = 1'b1;
        end
      end
      default: ;
    endcase

    starve_d = '0;
    if (!empty && !pop) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end
    hold_d = hold_q;
    if (pop) begin
      hold_d = 1'b0;
    end else if (starve_q == SW'(STARVE_MAX)) begin
      hold_d = 1'b1;
    end

    set_vec = (iss_valid && (iss_rd != '0)) ? (32'd1 << iss_rd) : '0;
    clr_vec = pop ? (32'd1 << head.rd) : '0;
    pend_d  = set_vec | (pend_q & ~clr_vec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a3_q     <= '0;
      wd_q     <= '0;
      rfwr_q   <= 1'b0;
      hold_q   <= 1'b0;
      pend_q   <= '0;
      starve_q <= '0;
    end else begin
      a3_q     <= a3_d;
      wd_q     <= wd_d;
      rfwr_q   <= rfwr_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end

`ifdef WB_TRACE_EN
  src_e src_q;

  always_ff @(posedge clk) begin
    src_q <= rst ? SRC_NONE : sel;
  end

  always @(posedge clk) begin
    if (rfwr_q) begin
      $display("[WB] A3=%0d WD=%h src=%s fifo_cnt=%0d", a3_q, wd_q,
               (src_q == SRC_PIPE) ? "PIPE" : "ASYNC", fifo_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter: a queue-based reference model
// pushes expected outputs each edge, a negedge monitor pops and compares.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we, as_valid, iss_valid;
  logic [AW-1:0] pipe_rd, as_rd, iss_rd;
  logic [DW-1:0] pipe_wd, as_wd;
  logic          pipe_hold, as_ready, RFWr;
  logic [31:0]   pend_mask;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic [2:0]    fifo_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .pipe_we  (pipe_we),
    .pipe_rd  (pipe_rd),
    .pipe_wd  (pipe_wd),
    .pipe_hold(pipe_hold),
    .as_valid (as_valid),
    .as_ready (as_ready),
    .as_rd    (as_rd),
    .as_wd    (as_wd),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .pend_mask(pend_mask),
    .A3       (A3),
    .WD       (WD),
    .RFWr     (RFWr),
    .fifo_cnt (fifo_cnt)
  );

  typedef struct {
    logic          rfwr;
    logic          chk_data;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic [31:0]   pend;
    int            cnt;
    logic          hold;
  } exp_t;

  exp_t      exp_q[$];
  int        checks = 0;
  int        errors = 0;

  wb_entry_t m_fifo[$];
  logic [31:0] m_pend;
  int        m_starve;
  logic      m_hold;

  // Reference model: arbitration rules applied to a plain queue at every edge.
  always @(posedge clk) begin : model
    exp_t      e;
    wb_entry_t h, n;
    bit        p, do_pop, do_push;
    e.rfwr = 1'b0; e.chk_data = 1'b0; e.a3 = '0; e.wd = '0;
    if (rst) begin
      m_fifo.delete();
      m_pend   = '0;
      m_starve = 0;
      m_hold   = 1'b0;
      e.chk_data = 1'b1;
    end else begin
      p       = pipe_we && (pipe_rd != 0);
      do_pop  = !p && (m_fifo.size() > 0);
      do_push = as_valid && (m_fifo.size() < DEPTH);
      h       = do_pop ? m_fifo[0] : '0;
      if (p) begin
        e.rfwr = 1'b1; e.chk_data = 1'b1; e.a3 = pipe_rd; e.wd = pipe_wd;
      end else if (do_pop && h.rd != 0) begin
        e.rfwr = 1'b1; e.chk_data = 1'b1; e.a3 = h.rd; e.wd = h.wd;
      end
      if (do_pop) m_pend[h.rd] = 1'b0;
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      if (do_pop) m_hold = 1'b0;
      else if (m_starve == SMAX) m_hold = 1'b1;
      if (m_fifo.size() > 0 && !do_pop) m_starve = m_starve + 1;
      else m_starve = 0;
      if (do_pop) void'(m_fifo.pop_front());
      if (do_push) begin
        n.rd = as_rd;
        n.wd = as_wd;
        m_fifo.push_back(n);
      end
    end
    e.pend = m_pend;
    e.cnt  = m_fifo.size();
    e.hold = m_hold;
    exp_q.push_back(e);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("RFWr", 32'(RFWr), 32'(e.rfwr));
    if (e.chk_data) begin
      cmp("A3", 32'(A3), 32'(e.a3));
      cmp("WD", WD, e.wd);
    end
    cmp("pend_mask", pend_mask, e.pend);
    cmp("fifo_cnt", 32'(fifo_cnt), 32'(e.cnt));
    cmp("as_ready", 32'(as_ready), 32'(e.cnt < DEPTH));
    cmp("pipe_hold", 32'(pipe_hold), 32'(e.hold));
  endtask

  // Monitor: compare DUT outputs half a cycle after each edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic applyStimulus(input logic r, input logic pw, input logic [AW-1:0] prd,
                               input logic [DW-1:0] pwd, input logic av,
                               input logic [AW-1:0] ard, input logic [DW-1:0] awd,
                               input logic iv, input logic [AW-1:0] ird);
    @(negedge clk);
    rst = r; pipe_we = pw; pipe_rd = prd; pipe_wd = pwd;
    as_valid = av; as_rd = ard; as_wd = awd; iss_valid = iv; iss_rd = ird;
  endtask

  function automatic logic [AW-1:0] nz();
    return AW'($urandom_range(1, 31));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pipeline busy with a nonzero destination, optionally pushing an async result.
  task automatic busy(input logic av, input logic [AW-1:0] ard);
    applyStimulus(0, 1, nz(), $urandom, av, ard, $urandom, 0, 0);
  endtask

  initial begin
    rst = 1'b1; pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    as_valid = 0; as_rd = 0; as_wd = 0; iss_valid = 0; iss_rd = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Pipeline-only writes, including a dropped r0 write.
    applyStimulus(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, $urandom, 0, 0, 0, 0, 0);
    idle(1);

    // Async path with scoreboard set/clear.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
    applyStimulus(0, 0, 0, 0, 1, 9, 32'hCAFE, 0, 0);
    idle(3);

    // Starvation: keep the pipeline busy until hold rises, then drain.
    busy(1, nz());
    busy(1, nz());
    for (int i = 0; i < 20 && !pipe_hold; i++) busy(0, 0);
    checks++;
    if (pipe_hold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_timeout actual=%b expected=1", pipe_hold);
    end
    idle(4);

    // Fill past full, then pop with a concurrent push.
    for (int i = 0; i < 5; i++) busy(1, nz());
    applyStimulus(0, 0, 0, 0, 1, nz(), $urandom, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, nz(), $urandom, 0, 0);
    idle(6);

    // Issue to r7 in the same cycle its older result pops.
    busy(1, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    idle(2);

    // Reset held for two cycles with three entries queued.
    for (int i = 0; i < 3; i++) busy(1, nz());
    applyStimulus(1, 1, nz(), $urandom, 1, nz(), $urandom, 1, nz());
    applyStimulus(1, 1, nz(), $urandom, 1, nz(), $urandom, 1, nz());
    idle(2);

    // Randomized traffic, mostly respecting pipe_hold.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0),
                    pipe_hold ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 4) < 3),
                    AW'($urandom), $urandom,
                    $urandom_range(0, 1) == 1, AW'($urandom), $urandom,
                    $urandom_range(0, 9) < 3, AW'($urandom));
    end
    idle(10);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
